// File: rtl/rglib_derotate_if.sv
// Handshake bundle for the rglib de-rotate pipeline.
// master: the side that produces input beats and consumes output beats.
// slave : the de-rotate block itself.
interface rglib_derotate_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ROT_WIDTH  = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ROT_WIDTH-1:0]  rotate_val;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, rotate_val, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rotate_val, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rglib_derotate.sv
// rglib_derotate: pipelined right-rotate that undoes the rglib left rotator.
// Stage k rotates right by 2^k when bit k of rotate_val is set, so a beat
// leaves the last stage fully de-rotated after ROT_WIDTH registered stages.
// The whole pipe advances together under valid/ready backpressure. kill
// flushes every in-flight beat but leaves the data registers untouched.
// Optional feature macro: RGLIB_DEROTATE_CNT_EN adds a 32-bit output-beat
// counter on port out_cnt. Without it the port and counter do not exist.
module rglib_derotate #(
    parameter int DATA_WIDTH = 64,
    parameter int ROT_WIDTH  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               kill,
    rglib_derotate_if.slave    bus
`ifdef RGLIB_DEROTATE_CNT_EN
    ,
    output logic [31:0]        out_cnt
`endif
);

    // Stage registers. rot_r[k] holds the rotate bits still to be applied,
    // shifted so that bit 0 always belongs to the next stage.
    logic [ROT_WIDTH-1:0]  valid_r;
    logic [DATA_WIDTH-1:0] data_r [ROT_WIDTH];
    logic [ROT_WIDTH-1:0]  rot_r  [ROT_WIDTH];

    // Per-stage inputs and the rotated value each stage will capture.
    logic                  v_in_s      [ROT_WIDTH];
    logic [DATA_WIDTH-1:0] d_in_s      [ROT_WIDTH];
    logic [ROT_WIDTH-1:0]  r_in_s      [ROT_WIDTH];
    logic [DATA_WIDTH-1:0] next_data_s [ROT_WIDTH];

    logic advance_s;

    // The pipe moves when the last stage is empty or being drained.
    assign advance_s    = !valid_r[ROT_WIDTH-1] || bus.out_ready;
    assign bus.in_ready = advance_s;
    assign bus.out_valid = valid_r[ROT_WIDTH-1];
    assign bus.out_data  = data_r[ROT_WIDTH-1];

    for (genvar k = 0; k < ROT_WIDTH; k++) begin : g_stage
        localparam int SH = 2 ** k;

        if (k == 0) begin : g_first
            assign v_in_s[k] = bus.in_valid;
            assign d_in_s[k] = bus.in_data;
            assign r_in_s[k] = bus.rotate_val;
        end else begin : g_next
            assign v_in_s[k] = valid_r[k-1];
            assign d_in_s[k] = data_r[k-1];
            assign r_in_s[k] = rot_r[k-1];
        end

        // Right rotation by 2^k: the low SH bits wrap around to the top.
        assign next_data_s[k] = r_in_s[k][0]
                              ? {d_in_s[k][SH-1:0], d_in_s[k][DATA_WIDTH-1:SH]}
                              : d_in_s[k];
    end

    // Stage registers: reset clears everything, kill clears only the valids,
    // otherwise every stage shifts forward together when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int k = 0; k < ROT_WIDTH; k++) begin
                data_r[k] <= '0;
                rot_r[k]  <= '0;
            end
        end else if (kill) begin
            valid_r <= '0;
        end else if (advance_s) begin
            for (int k = 0; k < ROT_WIDTH; k++) begin
                valid_r[k] <= v_in_s[k];
                data_r[k]  <= next_data_s[k];
                rot_r[k]   <= r_in_s[k] >> 1'b1;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

`ifdef RGLIB_DEROTATE_CNT_EN
    logic [31:0] out_cnt_r;

    // Count output fires; wraps naturally and is untouched by kill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_r <= 32'd0;
        end else if (bus.out_valid && bus.out_ready) begin
            out_cnt_r <= out_cnt_r + 32'd1;
        end else begin
            out_cnt_r <= out_cnt_r;
        end
    end

    assign out_cnt = out_cnt_r;
`endif

endmodule

// File: tb/tb_rglib_derotate.sv
// Directed bench for rglib_derotate at DATA_WIDTH=8, ROT_WIDTH=3.
// Single-beat latency table, streaming, backpressure, kill and mid-stream reset.
module tb_rglib_derotate;
    localparam int DW = 8;
    localparam int RW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic kill  = 1'b0;

    always #5 clk = ~clk;

    rglib_derotate_if #(.DATA_WIDTH(DW), .ROT_WIDTH(RW)) bus_if ();

`ifdef RGLIB_DEROTATE_CNT_EN
    logic [31:0] out_cnt;
`endif

    rglib_derotate #(.DATA_WIDTH(DW), .ROT_WIDTH(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kill  (kill),
        .bus   (bus_if.slave)
`ifdef RGLIB_DEROTATE_CNT_EN
        ,
        .out_cnt (out_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] got_q [$];

    typedef struct {
        logic [DW-1:0] din;
        logic [RW-1:0] rot;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    // Record every output fire as seen by the downstream consumer.
    always @(negedge clk) begin
        if (rst_n && bus_if.out_valid && bus_if.out_ready)
            got_q.push_back(bus_if.out_data);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [RW-1:0] r);
        bus_if.in_valid   = v;
        bus_if.in_data    = d;
        bus_if.rotate_val = r;
    endtask

    // One beat with out_ready high: not visible after two edges, visible after three.
    task automatic send_single(input logic [DW-1:0] d, input logic [RW-1:0] r,
                               input logic [DW-1:0] e, input string nm);
        step(); drive(1'b1, d, r); smp();
        step(); drive(1'b0, 8'h00, 3'd0); smp();
        step(); smp();
        chk({nm, "_early"}, bus_if.out_valid, 1'b0);
        step(); smp();
        chk({nm, "_valid"}, bus_if.out_valid, 1'b1);
        chk({nm, "_data"}, bus_if.out_data, e);
    endtask

    logic [DW-1:0] stream_exp [8];
    logic [DW-1:0] bp_d [4];
    logic [RW-1:0] bp_r [4];
    logic [DW-1:0] bp_e [4];

    initial begin
        vecs[0] = '{8'h81, 3'd1, 8'hC0};
        vecs[1] = '{8'h01, 3'd3, 8'h20};
        vecs[2] = '{8'hA5, 3'd0, 8'hA5};
        vecs[3] = '{8'h01, 3'd7, 8'h02};
        vecs[4] = '{8'h96, 3'd4, 8'h69};
        vecs[5] = '{8'h3C, 3'd2, 8'h0F};
        vecs[6] = '{8'hF0, 3'd5, 8'h87};
        vecs[7] = '{8'h12, 3'd6, 8'h48};
        stream_exp = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
        bp_d = '{8'h11, 8'h03, 8'h0F, 8'h80};
        bp_r = '{3'd1, 3'd1, 3'd4, 3'd7};
        bp_e = '{8'h88, 8'h81, 8'hF0, 8'h01};

        drive(1'b0, 8'h00, 3'd0);
        bus_if.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", bus_if.out_valid, 1'b0);
        chk("rst_out_data", bus_if.out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus_if.in_ready, 1'b1);

        // Single beats with exact latency
        for (int i = 0; i < 8; i++)
            send_single(vecs[i].din, vecs[i].rot, vecs[i].exp, $sformatf("vec%0d", i));

        // Streaming: 8 back-to-back beats, outputs with no gaps
        for (int c = 0; c < 11; c++) begin
            step();
            if (c < 8) drive(1'b1, 8'h01, RW'(c));
            else       drive(1'b0, 8'h00, 3'd0);
            smp();
            if (c >= 3) begin
                chk($sformatf("stream%0d_valid", c - 3), bus_if.out_valid, 1'b1);
                chk($sformatf("stream%0d_data", c - 3), bus_if.out_data, stream_exp[c - 3]);
            end
        end

        // Backpressure: fill, stall 5 cycles, release, expect exact order
        step();
        got_q.delete();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, bp_d[c], bp_r[c]);
            smp();
            step();
        end
        bus_if.out_ready = 1'b0;
        drive(1'b1, bp_d[3], bp_r[3]);
        for (int s = 0; s < 5; s++) begin
            smp();
            chk("bp_in_ready", bus_if.in_ready, 1'b0);
            chk("bp_out_valid", bus_if.out_valid, 1'b1);
            chk("bp_out_data", bus_if.out_data, bp_e[0]);
            step();
        end
        bus_if.out_ready = 1'b1;
        smp();
        chk("bp_release_in_ready", bus_if.in_ready, 1'b1);
        step();
        drive(1'b0, 8'h00, 3'd0);
        for (int s = 0; s < 10; s++) step();
        chk("bp_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) chk($sformatf("bp_order%0d", i), got_q[i], bp_e[i]);

        // Kill with three beats in flight and one offered, output stalled
        got_q.delete();
        bus_if.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 8'h55 + DW'(c), 3'd1);
            smp();
            step();
        end
        drive(1'b1, 8'hC3, 3'd2);
        kill = 1'b1;
        smp();
        chk("kill_pre_valid", bus_if.out_valid, 1'b1);
        step();
        kill = 1'b0;
        drive(1'b0, 8'h00, 3'd0);
        bus_if.out_ready = 1'b1;
        smp();
        chk("kill_out_valid", bus_if.out_valid, 1'b0);
        for (int s = 0; s < 6; s++) begin
            step(); smp();
            chk("kill_no_emerge", bus_if.out_valid, 1'b0);
        end
        step();
        chk("kill_none_fired", got_q.size(), 0);
        send_single(8'h81, 3'd1, 8'hC0, "post_kill");

        // Kill on an empty pipe with a beat offered: accepted, then dropped
        step();
        got_q.delete();
        drive(1'b1, 8'hFF, 3'd0);
        kill = 1'b1;
        smp();
        chk("kill_drop_in_ready", bus_if.in_ready, 1'b1);
        step();
        kill = 1'b0;
        drive(1'b0, 8'h00, 3'd0);
        for (int s = 0; s < 6; s++) step();
        chk("kill_drop_none", got_q.size(), 0);

`ifdef RGLIB_DEROTATE_CNT_EN
        chk("cnt_nonzero", (out_cnt != 32'd0), 1'b1);
`endif

        // Asynchronous reset mid-stream
        got_q.delete();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 8'h0F + DW'(c), 3'd3);
            smp();
            step();
        end
        drive(1'b0, 8'h00, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus_if.out_valid, 1'b0);
        chk("arst_out_data", bus_if.out_data, 8'h00);
`ifdef RGLIB_DEROTATE_CNT_EN
        chk("arst_out_cnt", out_cnt, 32'd0);
`endif
        smp();
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", bus_if.in_ready, 1'b1);
        for (int s = 0; s < 6; s++) step();
        chk("arst_none_fired", got_q.size(), 0);

`ifdef RGLIB_DEROTATE_CNT_EN
        for (int i = 0; i < 5; i++) send_single(8'h01, 3'd1, 8'h80, "cnt_beat");
        step();
        chk("cnt_five", out_cnt, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
